// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse
// Cleans a raw push-button/switch pin: 2-FF synchronizer, counter-based
// stability FSM, registered one-cycle rise/fall pulses and a wrapping press
// counter.
//
// state | meaning
// REL   | stable released
// W_P   | candidate press being timed
// PRS   | stable pressed
// W_R   | candidate release being timed
module btn_debounce_pulse #(
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned PCNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_raw,
  output logic              btn_level,
  output logic              btn_rise,
  output logic              btn_fall,
  output logic              busy,
  output logic [PCNT_W-1:0] press_cnt
);

  typedef enum logic [1:0] {
    REL = 2'd0,
    W_P = 2'd1,
    PRS = 2'd2,
    W_R = 2'd3
  } state_t;

  // Terminal count: the candidate level has been seen STABLE_CNT times in a row.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic              btn_norm;
  logic              s1_q, s2_q;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              level_q, level_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              busy_q, busy_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;

  assign btn_norm = ACTIVE_LOW ? ~btn_raw : btn_raw;

  // Two-stage synchronizer for the asynchronous pin; only s2_q feeds the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_norm;
      s2_q <= s1_q;
    end
  end

  // State, timer and all outputs are registered; a reset mid-wait drops the candidate.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REL;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // Next-state logic; any flip during a wait falls back to the stable state so
  // the timer never accumulates across a bounce.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    pcnt_d  = pcnt_q;
    case (state_q)
      REL: begin
        if (s2_q) begin
          state_d = W_P;
          cnt_d   = '0;
        end
      end
      W_P: begin
        if (!s2_q) begin
          state_d = REL;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRS;
          level_d = 1'b1;
          rise_d  = 1'b1;
          pcnt_d  = pcnt_q + PCNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRS: begin
        if (!s2_q) begin
          state_d = W_R;
          cnt_d   = '0;
        end
      end
      W_R: begin
        if (s2_q) begin
          state_d = PRS;
        end else if (cnt_q == CNT_LAST) begin
          state_d = REL;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = REL;
      end
    endcase
    busy_d = (state_d == W_P) || (state_d == W_R);
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;
  assign busy      = busy_q;
  assign press_cnt = pcnt_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse: active-high instance (dut) and
// active-low instance (dut_al), both with STABLE_CNT=4, PCNT_W=8.
module tb_btn_debounce_pulse;

  logic       clk;
  logic       rst;
  logic       btn_raw;
  logic       btn_raw_al;
  logic       btn_level, btn_rise, btn_fall, busy;
  logic [7:0] press_cnt;
  logic       al_level, al_rise, al_fall, al_busy;
  logic [7:0] al_cnt;

  int n_checks;
  int n_errors;

  btn_debounce_pulse #(
    .ACTIVE_LOW(1'b0), .STABLE_CNT(4), .CNT_W(16), .PCNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_rise(btn_rise), .btn_fall(btn_fall),
    .busy(busy), .press_cnt(press_cnt)
  );

  btn_debounce_pulse #(
    .ACTIVE_LOW(1'b1), .STABLE_CNT(4), .CNT_W(16), .PCNT_W(8)
  ) dut_al (
    .clk(clk), .rst(rst), .btn_raw(btn_raw_al),
    .btn_level(al_level), .btn_rise(al_rise), .btn_fall(al_fall),
    .busy(al_busy), .press_cnt(al_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run n edges on dut, counting pulses and busy cycles seen after each edge.
  task automatic run_edges(input int n, output int rises, output int falls, output int busys);
    rises = 0;
    falls = 0;
    busys = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (btn_rise) rises++;
      if (btn_fall) falls++;
      if (busy) busys++;
    end
  endtask

  int r, f, b;

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    btn_raw    = 1'b1;
    btn_raw_al = 1'b1;

    // 1: reset held 3 edges with the button pressed
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_level", {31'd0, btn_level}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_pulses", {30'd0, btn_rise, btn_fall}, 32'd0);
      chk("rst_cnt", {24'd0, press_cnt}, 32'd0);
    end
    rst = 1'b0;
    run_edges(6, r, f, b);
    chk("t1_no_early_rise", r, 0);
    chk("t1_level_e6", {31'd0, btn_level}, 32'd0);
    chk("t1_busy_e6", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_level_e7", {31'd0, btn_level}, 32'd1);
    chk("t1_rise_e7", {31'd0, btn_rise}, 32'd1);
    chk("t1_cnt", {24'd0, press_cnt}, 32'd1);
    chk("t1_busy_e7", {31'd0, busy}, 32'd0);
    tick();
    chk("t1_rise_e8", {31'd0, btn_rise}, 32'd0);

    // 2: clean release, then clean press held 20 cycles
    btn_raw = 1'b0;
    run_edges(6, r, f, b);
    chk("t2_rel_no_early_fall", f, 0);
    tick();
    chk("t2_fall_e7", {31'd0, btn_fall}, 32'd1);
    chk("t2_rel_level", {31'd0, btn_level}, 32'd0);
    chk("t2_rel_cnt", {24'd0, press_cnt}, 32'd1);
    btn_raw = 1'b1;
    run_edges(6, r, f, b);
    chk("t2_no_early_rise", r, 0);
    chk("t2_busy_cycles", b, 4);
    tick();
    chk("t2_rise_e7", {31'd0, btn_rise}, 32'd1);
    chk("t2_level_e7", {31'd0, btn_level}, 32'd1);
    chk("t2_cnt", {24'd0, press_cnt}, 32'd2);
    run_edges(13, r, f, b);
    chk("t2_single_rise", r, 0);
    chk("t2_level_held", {31'd0, btn_level}, 32'd1);

    // 3: release, then bounce every 2 cycles for 20 cycles, then hold pressed
    btn_raw = 1'b0;
    run_edges(10, r, f, b);
    chk("t3_pre_level", {31'd0, btn_level}, 32'd0);
    r = 0;
    for (int seg = 0; seg < 10; seg++) begin
      btn_raw = (seg % 2 == 0) ? 1'b1 : 1'b0;
      for (int k = 0; k < 2; k++) begin
        tick();
        if (btn_rise) r++;
      end
    end
    chk("t3_no_rise_bounce", r, 0);
    btn_raw = 1'b1;
    run_edges(6, r, f, b);
    chk("t3_no_early_rise", r, 0);
    tick();
    chk("t3_rise_e7", {31'd0, btn_rise}, 32'd1);
    chk("t3_cnt", {24'd0, press_cnt}, 32'd3);

    // 4: release with a 3-cycle glitch back to pressed
    run_edges(5, r, f, b);
    btn_raw = 1'b0;
    run_edges(2, r, f, b);
    btn_raw = 1'b1;
    run_edges(3, r, f, b);
    chk("t4_glitch_no_fall", f, 0);
    chk("t4_glitch_no_rise", r, 0);
    btn_raw = 1'b0;
    run_edges(6, r, f, b);
    chk("t4_no_early_fall", f, 0);
    tick();
    chk("t4_fall_e7", {31'd0, btn_fall}, 32'd1);
    chk("t4_no_both", {31'd0, btn_rise}, 32'd0);
    chk("t4_cnt_unchanged", {24'd0, press_cnt}, 32'd3);

    // 5: press counter wrap over 256 clean press/release pairs
    rst = 1'b1;
    run_edges(2, r, f, b);
    rst = 1'b0;
    chk("t5_cnt_reset", {24'd0, press_cnt}, 32'd0);
    for (int p = 1; p <= 256; p++) begin
      btn_raw = 1'b1;
      run_edges(8, r, f, b);
      if (p == 1)   chk("t5_cnt_p1", {24'd0, press_cnt}, 32'h01);
      if (p == 255) chk("t5_cnt_p255", {24'd0, press_cnt}, 32'hFF);
      if (p == 256) chk("t5_cnt_p256", {24'd0, press_cnt}, 32'h00);
      btn_raw = 1'b0;
      run_edges(8, r, f, b);
    end
    chk("t5_cnt_after_rel", {24'd0, press_cnt}, 32'h00);

    // 6: reset while W_P has counted to 2
    btn_raw = 1'b1;
    run_edges(5, r, f, b);
    chk("t6_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy_after", {31'd0, busy}, 32'd0);
    chk("t6_no_rise", {31'd0, btn_rise}, 32'd0);
    chk("t6_level", {31'd0, btn_level}, 32'd0);
    run_edges(6, r, f, b);
    chk("t6_requal_no_early", r, 0);
    tick();
    chk("t6_requal_rise_e7", {31'd0, btn_rise}, 32'd1);
    chk("t6_cnt", {24'd0, press_cnt}, 32'd1);

    // 7: active-low instance, pin driven low and held
    chk("t7_idle_level", {31'd0, al_level}, 32'd0);
    btn_raw_al = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t7_no_early_rise", {30'd0, al_level, al_rise}, 32'd0);
    end
    tick();
    chk("t7_level_e7", {31'd0, al_level}, 32'd1);
    chk("t7_rise_e7", {31'd0, al_rise}, 32'd1);
    chk("t7_cnt", {24'd0, al_cnt}, 32'd1);
    btn_raw_al = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("t7_no_early_fall", {31'd0, al_fall}, 32'd0);
    tick();
    chk("t7_fall_e7", {31'd0, al_fall}, 32'd1);
    chk("t7_rel_level", {31'd0, al_level}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
